locked_reg_programmer: RTL and testbench

Initiator-side sequencer that programs a bank of lockable 16-bit configuration registers and then locks them. Accepts write commands over a valid/ready handshake and drives each register's `Data_in`/`write`/`trusted`/`Lock` inputs. When enabled, it reads each write back and retries on mismatch. It sits between the boot/config master and the locked register bank, and enforces the same trusted-override policy as the registers.

---
 rtl/locked_reg_prog_pkg.sv | 24 ++
 rtl/locked_reg_prog_if.sv | 33 +++
 rtl/locked_reg_prog_dec.sv | 26 ++
 rtl/locked_reg_programmer.sv | 148 ++++++++++++++
 tb/tb_locked_reg_programmer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/locked_reg_prog_pkg.sv
// Shared types and constants for the locked register programmer.
package locked_reg_prog_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_LOCK   = 2'd3
  } state_e;

  // Plain-vector state codes for the sequencer's state register
  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_WRITE  = S_WRITE;
  localparam logic [1:0] ST_VERIFY = S_VERIFY;
  localparam logic [1:0] ST_LOCK   = S_LOCK;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_LOCKED = 2'b01;
  localparam logic [1:0] ERR_VERIFY = 2'b10;
  localparam logic [1:0] ERR_ADDR   = 2'b11;

  localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/locked_reg_prog_if.sv
// Command + register-bank bus of the locked register programmer.
// slave = programmer side, master = boot master / register bank side.
interface locked_reg_prog_if #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;
  logic                cmd_trusted;
  logic                cmd_last;
  logic [DATA_W-1:0]   Data_in;
  logic [NUM_REGS-1:0] write;
  logic                trusted;
  logic                Lock;
  logic [ADDR_W-1:0]   reg_sel;
  logic [DATA_W-1:0]   rd_data;
  logic                locked;
  logic                err;
  logic [1:0]          err_code;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_trusted, cmd_last, rd_data,
    output cmd_ready, Data_in, write, trusted, Lock, reg_sel, locked, err, err_code
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_trusted, cmd_last, rd_data,
    input  cmd_ready, Data_in, write, trusted, Lock, reg_sel, locked, err, err_code
  );
endinterface

// File: rtl/locked_reg_prog_dec.sv
// Registered address-to-one-hot write strobe decoder with enable.
module locked_reg_prog_dec #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                Clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] write
);
  logic [NUM_REGS-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign hit[gi] = (addr == ADDR_W'(gi));
    end
  endgenerate

  // Strobe is high for exactly the cycles the sequencer spends in WRITE
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) write <= '0;
    else         write <= en ? hit : '0;
  end
endmodule

// File: rtl/locked_reg_programmer.sv
// Sequencer that programs a bank of lockable registers and then locks them.
// Optional readback verify with retries: define LOCK_READBACK_VERIFY_EN.
module locked_reg_programmer
  import locked_reg_prog_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_RETRY = 3,
  parameter int ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input logic Clk,
  input logic resetn,
  locked_reg_prog_if.slave bus
);
  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, wr_addr;
  logic [DATA_W-1:0] data_reg;
  logic              trusted_reg, last_reg;
  logic              locked_reg, err_reg, ready_reg, trusted_out_reg, lock_reg;
  logic [1:0]        err_code_reg;
  logic              accept, bad_addr, denied, start, lock_due, wr_en, wr_trusted;

  assign accept     = bus.cmd_valid & ready_reg & (state_reg == ST_IDLE);
  assign bad_addr   = ({1'b0, bus.cmd_addr} >= NUM_REGS_C);
  assign denied     = locked_reg & ~bus.cmd_trusted;
  assign start      = accept & ~bad_addr & ~denied;
  assign lock_due   = last_reg & ~locked_reg;
  assign wr_en      = (state_next == ST_WRITE);
  // On the first write the command is not captured yet, so take it from the bus
  assign wr_addr    = start ? bus.cmd_addr : addr_reg;
  assign wr_trusted = start ? bus.cmd_trusted : trusted_reg;

`ifdef LOCK_READBACK_VERIFY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt;
  logic               mismatch, retry_ok;

  assign mismatch = (bus.rd_data != data_reg);
  assign retry_ok = (retry_cnt < MAX_RETRY_C);

  // Count re-attempts of the current command
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn)                                           retry_cnt <= '0;
    else if (start)                                        retry_cnt <= '0;
    else if (state_reg == ST_VERIFY && mismatch && retry_ok) retry_cnt <= retry_cnt + RETRY_W'(1);
  end
`else
  logic unused_rd_data;
  assign unused_rd_data = ^bus.rd_data;
`endif

  // Next-state selection for IDLE -> WRITE [-> VERIFY] [-> LOCK] -> IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_WRITE;
`ifdef LOCK_READBACK_VERIFY_EN
      ST_WRITE: state_next = ST_VERIFY;
      ST_VERIFY: begin
        if (!mismatch)     state_next = lock_due ? ST_LOCK : ST_IDLE;
        else if (retry_ok) state_next = ST_WRITE;
        else               state_next = ST_IDLE;
      end
`else
      ST_WRITE: state_next = lock_due ? ST_LOCK : ST_IDLE;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  // Capture the command and keep the sticky error status
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg     <= '0;
      data_reg     <= '0;
      trusted_reg  <= 1'b0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      if (start) begin
        addr_reg    <= bus.cmd_addr;
        data_reg    <= bus.cmd_data;
        trusted_reg <= bus.cmd_trusted;
        last_reg    <= bus.cmd_last;
      end
      if (accept) begin
        if (bad_addr) begin
          err_reg      <= 1'b1;
          err_code_reg <= ERR_ADDR;
        end else if (denied) begin
          err_reg      <= 1'b1;
          err_code_reg <= ERR_LOCKED;
        end else begin
          err_reg      <= 1'b0;
          err_code_reg <= ERR_NONE;
        end
      end
`ifdef LOCK_READBACK_VERIFY_EN
      else if (state_reg == ST_VERIFY && mismatch && !retry_ok) begin
        err_reg      <= 1'b1;
        err_code_reg <= ERR_VERIFY;
      end
`endif
    end
  end

  // State and registered control outputs, derived from the next state
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      ready_reg       <= 1'b1;
      trusted_out_reg <= 1'b0;
      lock_reg        <= 1'b0;
      locked_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ready_reg       <= (state_next == ST_IDLE);
      trusted_out_reg <= wr_en & wr_trusted;
      lock_reg        <= (state_next == ST_LOCK);
      if (state_next == ST_LOCK) locked_reg <= 1'b1;
    end
  end

  locked_reg_prog_dec #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .Clk    (Clk),
    .resetn (resetn),
    .en     (wr_en),
    .addr   (wr_addr),
    .write  (bus.write)
  );

  assign bus.cmd_ready = ready_reg;
  assign bus.Data_in   = data_reg;
  assign bus.trusted   = trusted_out_reg;
  assign bus.Lock      = lock_reg;
  assign bus.reg_sel   = addr_reg;
  assign bus.locked    = locked_reg;
  assign bus.err       = err_reg;
  assign bus.err_code  = err_code_reg;
endmodule

// File: tb/tb_locked_reg_programmer.sv
// Bench for locked_reg_programmer; works with or without LOCK_READBACK_VERIFY_EN.
module tb_locked_reg_programmer;
`ifdef LOCK_READBACK_VERIFY_EN
  localparam int LOCK_LAT = 3;
`else
  localparam int LOCK_LAT = 2;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic force_bad = 1'b0;
  always #5 clk = ~clk;

  locked_reg_prog_if #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(2)) a_if ();
  locked_reg_prog_if #(.NUM_REGS(3), .DATA_W(16), .ADDR_W(2)) b_if ();

  locked_reg_programmer #(.NUM_REGS(4), .DATA_W(16), .MAX_RETRY(3)) dut_a (
    .Clk(clk), .resetn(resetn), .bus(a_if));
  locked_reg_programmer #(.NUM_REGS(3), .DATA_W(16), .MAX_RETRY(3)) dut_b (
    .Clk(clk), .resetn(resetn), .bus(b_if));

  // Register bank model behind DUT A; force_bad corrupts the readback
  logic [15:0] bank [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!resetn)           bank[i] <= 16'h0;
      else if (a_if.write[i]) bank[i] <= a_if.Data_in;
    end
  end
  assign a_if.rd_data = force_bad ? ~bank[a_if.reg_sel] : bank[a_if.reg_sel];
  assign b_if.rd_data = 16'h0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected write strobes for DUT A
  typedef struct packed {
    logic [3:0]  wr;
    logic [15:0] data;
    logic        tr;
  } wexp_t;
  wexp_t sb_q[$];
  wexp_t sb_e;
  int wr_pulses = 0;
  int lock_pulses = 0;

  always @(negedge clk) begin
    if (resetn && (|a_if.write)) begin
      wr_pulses++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_write: got write=%b expected none", a_if.write);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_write", 32'(a_if.write), 32'(sb_e.wr));
        chk("sb_data", 32'(a_if.Data_in), 32'(sb_e.data));
        chk("sb_trusted", 32'(a_if.trusted), 32'(sb_e.tr));
      end
    end
    if (a_if.Lock) lock_pulses++;
  end

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic        tr;
    logic        last;
    logic [3:0]  exp_wr;
    logic        exp_lock;
    logic [1:0]  exp_code;
    logic        exp_locked;
  } vec_t;
  vec_t vecs[7];

  // Offer one command to DUT A and check the whole transaction
  task automatic send_a(input vec_t v, input int n_push, input int exp_lock_at);
    int k;
    int lock_at;
    k = 0;
    while (!a_if.cmd_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk("ready_before", 32'(a_if.cmd_ready), 32'd1);
    a_if.cmd_valid   = 1'b1;
    a_if.cmd_addr    = v.addr;
    a_if.cmd_data    = v.data;
    a_if.cmd_trusted = v.tr;
    a_if.cmd_last    = v.last;
    for (int i = 0; i < n_push; i++) sb_q.push_back(wexp_t'{v.exp_wr, v.data, v.tr});
    @(posedge clk); #1;
    a_if.cmd_valid = 1'b0;
    chk("write_t1", 32'(a_if.write), 32'(v.exp_wr));
    lock_at = a_if.Lock ? 1 : 0;
    k = 1;
    while (!a_if.cmd_ready && k < 20) begin
      @(posedge clk); #1; k++;
      if (a_if.Lock && lock_at == 0) lock_at = k;
    end
    chk("ready_after", 32'(a_if.cmd_ready), 32'd1);
    chk("lock_cycle", 32'(lock_at), 32'(exp_lock_at));
    chk("err", 32'(a_if.err), 32'(v.exp_code != 2'b00));
    chk("err_code", 32'(a_if.err_code), 32'(v.exp_code));
    chk("locked", 32'(a_if.locked), 32'(v.exp_locked));
    $display("txn addr=%0d data=%h tr=%0d last=%0d code=%b locked=%0d lock_at=%0d",
             v.addr, v.data, v.tr, v.last, a_if.err_code, a_if.locked, lock_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_base;
    int w0;
    vec_t rv;

    vecs[0] = '{2'd1, 16'h5555, 1'b0, 1'b0, 4'b0010, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{2'd2, 16'h1234, 1'b1, 1'b1, 4'b0100, 1'b1, 2'b00, 1'b1};
    vecs[2] = '{2'd1, 16'hBEEF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b01, 1'b1};
    vecs[3] = '{2'd0, 16'h00FF, 1'b1, 1'b1, 4'b0001, 1'b0, 2'b00, 1'b1};
    vecs[4] = '{2'd3, 16'hA5A5, 1'b1, 1'b0, 4'b1000, 1'b0, 2'b00, 1'b1};
    vecs[5] = '{2'd3, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b1};
    vecs[6] = '{2'd2, 16'hC3C3, 1'b1, 1'b0, 4'b0100, 1'b0, 2'b00, 1'b1};

    a_if.cmd_valid = 1'b0; a_if.cmd_addr = '0; a_if.cmd_data = '0;
    a_if.cmd_trusted = 1'b0; a_if.cmd_last = 1'b0;
    b_if.cmd_valid = 1'b0; b_if.cmd_addr = '0; b_if.cmd_data = '0;
    b_if.cmd_trusted = 1'b0; b_if.cmd_last = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_if.cmd_ready), 32'd1);
    chk("rst_write", 32'(a_if.write), 32'd0);
    chk("rst_lock", 32'(a_if.Lock), 32'd0);
    chk("rst_locked", 32'(a_if.locked), 32'd0);
    chk("rst_err", 32'(a_if.err), 32'd0);
    chk("rst_err_code", 32'(a_if.err_code), 32'd0);
    chk("rst_data_in", 32'(a_if.Data_in), 32'd0);
    chk("rst_trusted", 32'(a_if.trusted), 32'd0);
    chk("rst_reg_sel", 32'(a_if.reg_sel), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(a_if.cmd_ready), 32'd1);

    // Table-driven command sequence on DUT A
    for (int i = 0; i < 7; i++)
      send_a(vecs[i], (vecs[i].exp_wr != 4'b0000) ? 1 : 0, vecs[i].exp_lock ? LOCK_LAT : 0);

    // Bad address on the 3-register instance
    b_if.cmd_valid = 1'b1; b_if.cmd_addr = 2'd3; b_if.cmd_data = 16'h7777;
    b_if.cmd_trusted = 1'b1; b_if.cmd_last = 1'b0;
    @(posedge clk); #1;
    b_if.cmd_valid = 1'b0;
    chk("b_write", 32'(b_if.write), 32'd0);
    chk("b_err", 32'(b_if.err), 32'd1);
    chk("b_err_code", 32'(b_if.err_code), 32'd3);
    chk("b_ready", 32'(b_if.cmd_ready), 32'd1);
    @(posedge clk); #1;
    chk("b_write_next", 32'(b_if.write), 32'd0);
    $display("txn b addr=3 code=%b ready=%0d", b_if.err_code, b_if.cmd_ready);

    // Reset clears the lock
    resetn = 1'b0;
    #1;
    chk("rst2_locked", 32'(a_if.locked), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Reset during the cycle before LOCK of a last command aborts the lock
    lock_base = lock_pulses;
    a_if.cmd_valid = 1'b1; a_if.cmd_addr = 2'd2; a_if.cmd_data = 16'h6666;
    a_if.cmd_trusted = 1'b1; a_if.cmd_last = 1'b1;
    sb_q.push_back(wexp_t'{4'b0100, 16'h6666, 1'b1});
    @(posedge clk); #1;
    a_if.cmd_valid = 1'b0;
    repeat (LOCK_LAT - 2) begin @(posedge clk); #1; end
    #6;
    resetn = 1'b0;
    #1;
    chk("abort_write", 32'(a_if.write), 32'd0);
    chk("abort_lock", 32'(a_if.Lock), 32'd0);
    chk("abort_locked", 32'(a_if.locked), 32'd0);
    chk("abort_ready", 32'(a_if.cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_release", 32'(a_if.cmd_ready), 32'd1);
    chk("abort_locked_release", 32'(a_if.locked), 32'd0);
    chk("abort_no_lock_pulse", 32'(lock_pulses - lock_base), 32'd0);
    $display("txn abort addr=2 data=6666 locked=%0d", a_if.locked);

`ifdef LOCK_READBACK_VERIFY_EN
    // Readback always wrong: 1 + MAX_RETRY writes, verify error, no lock
    force_bad = 1'b1;
    rv = '{2'd1, 16'h0F0F, 1'b1, 1'b1, 4'b0010, 1'b0, 2'b10, 1'b0};
    w0 = wr_pulses;
    send_a(rv, 4, 0);
    chk("retry_writes", 32'(wr_pulses - w0), 32'd4);
    force_bad = 1'b0;
`else
    w0 = wr_pulses;
    rv = '{2'd1, 16'h0F0F, 1'b1, 1'b0, 4'b0010, 1'b0, 2'b00, 1'b0};
    send_a(rv, 1, 0);
    chk("single_write", 32'(wr_pulses - w0), 32'd1);
`endif

    @(posedge clk); #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("total_lock_pulses", 32'(lock_pulses), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
